// File: rtl/video_read_port.sv
// -----------------------------------------------------------------------------
// video_read_port
//
// Takes one burst read request from the video character-row preload logic and
// splits it into SDRAM read commands. Each command is at most MAX_CHUNK words
// and never crosses an SDRAM row of ROW_WORDS words. Returned words are passed
// back to the video side in order, one registered rd_available strobe per word.
//
// Optional statistics counters are built only when the macro
// VIDEO_READ_PORT_STATS_EN is defined. Otherwise burst_count and drop_count
// are tied to zero.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rd_request        one-cycle pulse that starts a burst
//   rd_address        burst start word address, sampled with rd_request
//   rd_burst_length   burst word count (0 is ignored), sampled with rd_request
//   rd_available      one-cycle strobe, rd_data valid
//   rd_data           returned word
//   busy              burst in progress
//   cmd_valid/ready   SDRAM read command handshake
//   cmd_address       chunk start word address
//   cmd_length        chunk word count, 1..MAX_CHUNK
//   resp_valid/data   SDRAM read word return
//   burst_count       completed bursts (wraps at 16 bits)
//   drop_count        requests ignored while busy (saturates at 255)
// -----------------------------------------------------------------------------
module video_read_port #(
   parameter int ADDR_WIDTH = 23,
   parameter int LEN_WIDTH  = 9,
   parameter int MAX_CHUNK  = 8,
   parameter int ROW_WORDS  = 256,
   localparam int CLEN_WIDTH = $clog2(MAX_CHUNK) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_request,
   input  logic [ADDR_WIDTH-1:0] rd_address,
   input  logic [LEN_WIDTH-1:0]  rd_burst_length,
   output logic                  rd_available,
   output logic [31:0]           rd_data,
   output logic                  busy,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] cmd_address,
   output logic [CLEN_WIDTH-1:0] cmd_length,
   input  logic                  resp_valid,
   input  logic [31:0]           resp_data,
   output logic [15:0]           burst_count,
   output logic [7:0]            drop_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                state, next_state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [CLEN_WIDTH-1:0] chunk_left;
   logic                  accept;     // command handshake this cycle
   logic                  last_word;  // final word of the current chunk arrives

   // Chunk size = min(words left, MAX_CHUNK, words left in the current row).
   // ROW_WORDS is a power of two, so the modulo is just the low address bits.
   function automatic logic [CLEN_WIDTH-1:0] chunk_len(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [LEN_WIDTH-1:0]  rem
   );
      logic [31:0] room;
      logic [31:0] len;
      room = 32'(ROW_WORDS) - (32'(addr) % 32'(ROW_WORDS));
      len  = 32'(rem);
      if (len > 32'(MAX_CHUNK)) len = 32'(MAX_CHUNK);
      if (len > room)           len = room;
      return CLEN_WIDTH'(len);
   endfunction

   // cur_addr always holds the start of the next chunk, so it doubles as the
   // command address; it only matters while cmd_valid is high.
   assign cmd_address = cur_addr;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      next_state = state;
      busy       = 1'b1;
      cmd_valid  = 1'b0;
      accept     = 1'b0;
      last_word  = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (rd_request && (rd_burst_length != '0)) next_state = ISSUE;
         end
         ISSUE: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               accept     = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            // remaining was already reduced when the command was accepted
            if (resp_valid && (chunk_left == CLEN_WIDTH'(1))) begin
               last_word  = 1'b1;
               next_state = (remaining != '0) ? ISSUE : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cur_addr     <= '0;
         remaining    <= '0;
         chunk_left   <= '0;
         cmd_length   <= '0;
         rd_available <= 1'b0;
         rd_data      <= '0;
      end else begin
         state        <= next_state;
         rd_available <= 1'b0;
         case (state)
            IDLE: begin
               if (next_state == ISSUE) begin
                  cur_addr   <= rd_address;
                  remaining  <= rd_burst_length;
                  cmd_length <= chunk_len(rd_address, rd_burst_length);
               end
            end
            ISSUE: begin
               // cmd_length is untouched here, so it holds under backpressure
               if (accept) begin
                  chunk_left <= cmd_length;
                  cur_addr   <= cur_addr + ADDR_WIDTH'(cmd_length);
                  remaining  <= remaining - LEN_WIDTH'(cmd_length);
               end
            end
            WAIT: begin
               if (resp_valid) begin
                  rd_available <= 1'b1;
                  rd_data      <= resp_data;
                  chunk_left   <= chunk_left - CLEN_WIDTH'(1);
                  if (last_word && (remaining != '0))
                     cmd_length <= chunk_len(cur_addr, remaining);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef VIDEO_READ_PORT_STATS_EN
   logic [15:0] burst_q;
   logic [7:0]  drop_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         burst_q <= '0;
         drop_q  <= '0;
      end else begin
         if (last_word && (remaining == '0)) burst_q <= burst_q + 16'd1;
         if (rd_request && busy && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
      end
   end

   assign burst_count = burst_q;
   assign drop_count  = drop_q;
`else
   assign burst_count = '0;
   assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_video_read_port.sv
// -----------------------------------------------------------------------------
// tb_video_read_port
//
// Directed bench for video_read_port. A small SDRAM model answers each accepted
// command with its words after two cycles. Expected commands and expected
// returned words are queued when a burst is started and compared as the DUT
// produces them.
// -----------------------------------------------------------------------------
module tb_video_read_port;

   localparam int AW = 23;
   localparam int LW = 9;
   localparam int CW = 4;

`ifdef VIDEO_READ_PORT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          rd_request;
   logic [AW-1:0] rd_address;
   logic [LW-1:0] rd_burst_length;
   logic          rd_available;
   logic [31:0]   rd_data;
   logic          busy;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_address;
   logic [CW-1:0] cmd_length;
   logic          resp_valid = 1'b0;
   logic [31:0]   resp_data  = '0;
   logic [15:0]   burst_count;
   logic [7:0]    drop_count;

   video_read_port dut (
      .clk            (clk),
      .reset          (reset),
      .rd_request     (rd_request),
      .rd_address     (rd_address),
      .rd_burst_length(rd_burst_length),
      .rd_available   (rd_available),
      .rd_data        (rd_data),
      .busy           (busy),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_address    (cmd_address),
      .cmd_length     (cmd_length),
      .resp_valid     (resp_valid),
      .resp_data      (resp_data),
      .burst_count    (burst_count),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {int due; logic [31:0] data;} resp_t;
   typedef struct {logic [AW-1:0] addr; logic [CW-1:0] len;} cmd_t;

   resp_t       pend[$];      // words the SDRAM model still has to return
   cmd_t        exp_cmd[$];   // scoreboard: expected commands
   logic [31:0] exp_data[$];  // scoreboard: expected returned words
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   cmd_t        mon_c;
   resp_t       drv_r;

   function automatic logic [31:0] word_of(input logic [AW-1:0] a);
      return 32'(a) ^ 32'h5A00_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SDRAM model: one word per cycle from the pending queue once it is due.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         drv_r      = pend.pop_front();
         resp_valid = 1'b1;
         resp_data  = drv_r.data;
      end else begin
         resp_valid = 1'b0;
      end
   end

   // Monitor: sampled mid-cycle, so values are those the next edge will see.
   always @(negedge clk) begin
      if (rd_available) begin
         if (exp_data.size() == 0) check("unexpected_strobe", rd_available, 1'b0);
         else                      check("rd_data", rd_data, exp_data.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
         for (int k = 0; k < int'(cmd_length); k++)
            pend.push_back('{due: cyc + 2 + k, data: word_of(cmd_address + AW'(k))});
         if (exp_cmd.size() == 0) begin
            check("unexpected_cmd", cmd_valid, 1'b0);
         end else begin
            mon_c = exp_cmd.pop_front();
            check("cmd_address", cmd_address, mon_c.addr);
            check("cmd_length", cmd_length, mon_c.len);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit expect_words);
      if (expect_words)
         for (int i = 0; i < int'(l); i++) exp_data.push_back(word_of(a + AW'(i)));
      rd_request      = 1'b1;
      rd_address      = a;
      rd_burst_length = l;
      step();
      rd_request      = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy) begin
            check({tag, "_last_word_at_busy_fall"}, rd_available, 1'b1);
            break;
         end
         n++;
         if (n > budget) begin
            check({tag, "_timeout"}, busy, 1'b0);
            break;
         end
      end
      step();
      check({tag, "_words_left"}, 64'(exp_data.size()), 64'd0);
      check({tag, "_cmds_left"}, 64'(exp_cmd.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_cmd_valid"}, cmd_valid, 1'b0);
      check({tag, "_rd_available"}, rd_available, 1'b0);
      check({tag, "_rd_data"}, rd_data, 32'd0);
      check({tag, "_cmd_address"}, cmd_address, '0);
      check({tag, "_cmd_length"}, cmd_length, '0);
      check({tag, "_burst_count"}, burst_count, 16'd0);
      check({tag, "_drop_count"}, drop_count, 8'd0);
   endtask

   initial begin
      int n;
      reset           = 1'b1;
      rd_request      = 1'b0;
      rd_address      = '0;
      rd_burst_length = '0;
      cmd_ready       = 1'b1;

      // Reset state
      repeat (3) step();
      check_reset_outputs("reset");
      reset = 1'b0;
      step();

      // Aligned burst: five 8-word commands from 0x100
      for (int i = 0; i < 5; i++) exp_cmd.push_back('{addr: AW'(32'h100 + 8 * i), len: CW'(8)});
      start_burst(AW'(32'h100), LW'(40), 1'b1);
      check("aligned_busy", busy, 1'b1);
      wait_idle("aligned", 400);
      check("aligned_burst_count", burst_count, STATS ? 16'd1 : 16'd0);

      // Row crossing: 0xFC..0x105 splits at the row boundary
      exp_cmd.push_back('{addr: AW'(32'h0FC), len: CW'(4)});
      exp_cmd.push_back('{addr: AW'(32'h100), len: CW'(6)});
      start_burst(AW'(32'h0FC), LW'(10), 1'b1);
      wait_idle("row_cross", 200);

      // Backpressure: command held for 5 cycles, accepted on first ready
      cmd_ready = 1'b0;
      exp_cmd.push_back('{addr: AW'(32'h300), len: CW'(3)});
      start_burst(AW'(32'h300), LW'(3), 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bp_cmd_valid", cmd_valid, 1'b1);
         check("bp_cmd_address", cmd_address, AW'(32'h300));
         check("bp_cmd_length", cmd_length, CW'(3));
         if (i < 4) step();
      end
      cmd_ready = 1'b1;
      step();
      check("bp_accepted", cmd_valid, 1'b0);
      wait_idle("backpressure", 100);

      // Busy drop: a second request mid-burst must have no effect
      for (int i = 0; i < 5; i++) exp_cmd.push_back('{addr: AW'(32'h200 + 8 * i), len: CW'(8)});
      start_burst(AW'(32'h200), LW'(40), 1'b1);
      repeat (6) step();
      start_burst(AW'(32'h700), LW'(5), 1'b0);
      wait_idle("busy_drop", 400);
      check("busy_drop_drop_count", drop_count, STATS ? 8'd1 : 8'd0);
      check("busy_drop_burst_count", burst_count, STATS ? 16'd4 : 16'd0);

      // Zero length request is ignored, stray response in IDLE is dropped
      start_burst(AW'(32'h050), LW'(0), 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("zero_len_busy", busy, 1'b0);
         check("zero_len_cmd_valid", cmd_valid, 1'b0);
         step();
      end
      check("zero_len_drop_count", drop_count, STATS ? 8'd1 : 8'd0);
      pend.push_back('{due: cyc, data: 32'hDEAD_BEEF});
      for (int i = 0; i < 4; i++) begin
         step();
         check("stray_rd_available", rd_available, 1'b0);
      end
      check("stray_delivered", 64'(pend.size()), 64'd0);

      // Reset in WAIT after 3 of 8 words
      exp_cmd.push_back('{addr: AW'(32'h400), len: CW'(8)});
      start_burst(AW'(32'h400), LW'(8), 1'b1);
      n = 0;
      for (int i = 0; i < 50 && n < 3; i++) begin
         step();
         if (rd_available) n++;
      end
      check("reset_mid_wait_reached", 64'(n), 64'd3);
      reset = 1'b1;
      // the third word is popped by the monitor this cycle; the rest never come
      while (exp_data.size() > 1) void'(exp_data.pop_back());
      step();
      check_reset_outputs("reset_mid_wait");
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("post_reset_rd_available", rd_available, 1'b0);
         check("post_reset_busy", busy, 1'b0);
      end
      check("post_reset_resps_drained", 64'(pend.size()), 64'd0);
      check("post_reset_words_left", 64'(exp_data.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
